// File: rtl/regfile_write_scheduler_pkg.sv
// Shared definitions for the register-file write scheduler: register count,
// default widths and the sequencer state type.
package regfile_write_scheduler_pkg;

    localparam int REG_COUNT          = 32;
    localparam int DEFAULT_DATA_WIDTH = 64;
    localparam int DEFAULT_ADDR_WIDTH = 5;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_write_arbiter.sv
// Grant logic for the shared write port: fixed load-unit priority, or a
// last-grant round-robin pointer when REGFILE_ARB_ROUND_ROBIN_EN is defined.
module regfile_write_arbiter (
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    input  logic clock,
    input  logic reset,
`endif
    input  logic enable,
    input  logic alu_valid,
    input  logic mem_valid,
    output logic alu_grant,
    output logic mem_grant
);

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    // 1 = ALU was granted last; reset value makes the load unit win first.
    logic last_alu_q;
    logic last_alu_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_alu_q <= 1'b1;
        end else begin
            last_alu_q <= last_alu_d;
        end
    end

    always_comb begin
        last_alu_d = last_alu_q;
        if (alu_grant) begin
            last_alu_d = 1'b1;
        end else if (mem_grant) begin
            last_alu_d = 1'b0;
        end
    end
`endif

    always_comb begin
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        if (enable) begin
            if (alu_valid && mem_valid) begin
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
                if (last_alu_q) begin
                    mem_grant = 1'b1;
                end else begin
                    alu_grant = 1'b1;
                end
`else
                mem_grant = 1'b1;
`endif
            end else begin
                alu_grant = alu_valid;
                mem_grant = mem_valid;
            end
        end
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Register-file write-port sequencer: zero sweep of x1..x31, then ALU/load
// writeback arbitration and pending-write scoreboard. Option: REGFILE_ARB_ROUND_ROBIN_EN.
module regfile_write_scheduler
    import regfile_write_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [ADDR_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_ready,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic [ADDR_WIDTH-1:0] rs1_address,
    input  logic [ADDR_WIDTH-1:0] rs2_address,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  init_done,
    output logic                  reg_write,
    output logic [ADDR_WIDTH-1:0] rd_address,
    output logic [DATA_WIDTH-1:0] write_data,
    output state_t                dbg_state
);

    // Handshake: a requester holds valid/rd/data stable until ready; a transfer
    // happens on a rising edge where valid && ready, and ready never waits on
    // anything registered other than the state and arbitration pointer.

    // One spare bit lets the sweep counter reach REG_COUNT without wrapping to x0.
    localparam int                 SWEEP_W   = ADDR_WIDTH + 1;
    localparam logic [SWEEP_W-1:0] SWEEP_END = SWEEP_W'(REG_COUNT);

    state_t                  state_q, state_d;
    logic [SWEEP_W-1:0]      sweep_q, sweep_d;
    logic                    init_done_q, init_done_d;
    logic                    reg_write_q, reg_write_d;
    logic [ADDR_WIDTH-1:0]   rd_address_q, rd_address_d;
    logic [DATA_WIDTH-1:0]   write_data_q, write_data_d;
    logic [REG_COUNT-1:0]    sb_q, sb_d;
    logic                    alu_grant, mem_grant;

    regfile_write_arbiter u_arbiter (
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
        .clock     (clock),
        .reset     (reset),
`endif
        .enable    (state_q == RUN),
        .alu_valid (alu_valid),
        .mem_valid (mem_valid),
        .alu_grant (alu_grant),
        .mem_grant (mem_grant)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= INIT;
            sweep_q      <= SWEEP_W'(1);
            init_done_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            rd_address_q <= '0;
            write_data_q <= '0;
            sb_q         <= '0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            init_done_q  <= init_done_d;
            reg_write_q  <= reg_write_d;
            rd_address_q <= rd_address_d;
            write_data_q <= write_data_d;
            sb_q         <= sb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == INIT) begin
            if (sweep_q == SWEEP_END) begin
                state_d = RUN;
            end else begin
                sweep_d = sweep_q + SWEEP_W'(1);
            end
        end
    end

    always_comb begin
        reg_write_d  = 1'b0;
        rd_address_d = '0;
        write_data_d = '0;
        init_done_d  = init_done_q;
        sb_d         = sb_q;
        if (state_q == INIT) begin
            if (sweep_q != SWEEP_END) begin
                reg_write_d  = 1'b1;
                rd_address_d = sweep_q[ADDR_WIDTH-1:0];
            end else begin
                init_done_d = 1'b1;
            end
        end else begin
            if (alu_grant) begin
                reg_write_d  = (alu_rd != '0);
                rd_address_d = alu_rd;
                write_data_d = alu_data;
                sb_d[alu_rd] = 1'b0;
            end else if (mem_grant) begin
                reg_write_d  = (mem_rd != '0);
                rd_address_d = mem_rd;
                write_data_d = mem_data;
                sb_d[mem_rd] = 1'b0;
            end
            // Applied after the clear so a same-cycle issue keeps the bit set.
            if (issue_valid && issue_rd != '0) begin
                sb_d[issue_rd] = 1'b1;
            end
        end
        sb_d[0] = 1'b0;
    end

    assign alu_ready  = alu_grant;
    assign mem_ready  = mem_grant;
    assign rs1_busy   = sb_q[rs1_address];
    assign rs2_busy   = sb_q[rs2_address];
    assign init_done  = init_done_q;
    assign reg_write  = reg_write_q;
    assign rd_address = rd_address_q;
    assign write_data = write_data_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler: behavioural model checked every
// cycle plus literal expectations for sweep, handshake, scoreboard and reset.
module tb_regfile_write_scheduler;
    import regfile_write_scheduler_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid, issue_valid;
    logic [4:0]  alu_rd, mem_rd, issue_rd, rs1_address, rs2_address;
    logic [63:0] alu_data, mem_data;
    logic        alu_ready, mem_ready, rs1_busy, rs2_busy, init_done, reg_write;
    logic [4:0]  rd_address;
    logic [63:0] write_data;
    state_t      dbg_state;

    int checks   = 0;
    int failures = 0;

    regfile_write_scheduler dut (
        .clock       (clock),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1_address (rs1_address),
        .rs2_address (rs2_address),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .init_done   (init_done),
        .reg_write   (reg_write),
        .rd_address  (rd_address),
        .write_data  (write_data),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_since counts non-reset edges since reset, saturating at 32 (= running).
    int          m_since = 0;
    bit          m_sb[32];
    bit          m_last_alu = 1'b1;
    bit          m_valid = 1'b0;
    bit          m_we = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [63:0] m_data = '0;
    bit          m_ga, m_gm, c_ga, c_gm;

    function automatic void model_grant(output bit ga, output bit gm);
        ga = 1'b0;
        gm = 1'b0;
        if (m_since < 32) return;
        if (alu_valid && mem_valid) begin
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
            if (m_last_alu) gm = 1'b1; else ga = 1'b1;
`else
            gm = 1'b1;
`endif
        end else if (alu_valid) begin
            ga = 1'b1;
        end else if (mem_valid) begin
            gm = 1'b1;
        end
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_since    = 0;
            foreach (m_sb[i]) m_sb[i] = 1'b0;
            m_last_alu = 1'b1;
            m_we       = 1'b0;
            m_valid    = 1'b1;
        end else if (m_since < 31) begin
            m_we   = 1'b1;
            m_rd   = 5'(m_since + 1);
            m_data = '0;
            m_since++;
        end else if (m_since == 31) begin
            m_we    = 1'b0;
            m_since = 32;
        end else begin
            model_grant(m_ga, m_gm);
            m_we = 1'b0;
            if (m_ga) begin
                m_we = (alu_rd != 0); m_rd = alu_rd; m_data = alu_data;
                m_sb[alu_rd] = 1'b0; m_last_alu = 1'b1;
            end
            if (m_gm) begin
                m_we = (mem_rd != 0); m_rd = mem_rd; m_data = mem_data;
                m_sb[mem_rd] = 1'b0; m_last_alu = 1'b0;
            end
            if (issue_valid && issue_rd != 0) m_sb[issue_rd] = 1'b1;
        end
    end

    // Compare process: every falling edge once the model has seen a reset.
    always @(negedge clock) begin
        if (m_valid) begin
            chk("m_reg_write", reg_write, m_we);
            if (m_we) begin
                chk("m_rd_address", rd_address, m_rd);
                chk("m_write_data", write_data, m_data);
            end
            chk("m_init_done", init_done, m_since == 32);
            chk("m_rs1_busy", rs1_busy, m_sb[rs1_address]);
            chk("m_rs2_busy", rs2_busy, m_sb[rs2_address]);
            if (!reset) begin
                model_grant(c_ga, c_gm);
                chk("m_alu_ready", alu_ready, c_ga);
                chk("m_mem_ready", mem_ready, c_gm);
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic [4:0] exp_q[$];
    logic [4:0] seen_q[$];
    int         serve_cycles;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Holds the current requests until each is accepted, logging writes seen.
    task automatic serve(input int budget);
        logic a, m;
        serve_cycles = 0;
        while ((alu_valid || mem_valid) && serve_cycles < budget) begin
            #1;
            a = alu_ready;
            m = mem_ready;
            tick();
            if (reg_write) seen_q.push_back(rd_address);
            if (a) alu_valid = 1'b0;
            if (m) mem_valid = 1'b0;
            serve_cycles++;
        end
        if (alu_valid || mem_valid) begin
            chk("serve_timeout", 1, 0);
            alu_valid = 1'b0;
            mem_valid = 1'b0;
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
        rs1_address = '0; rs2_address = '0;

        tick(); tick();
        chk("rst_reg_write", reg_write, 0);
        chk("rst_rd_address", rd_address, 0);
        chk("rst_write_data", write_data, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_mem_ready", mem_ready, 0);
        chk("rst_rs1_busy", rs1_busy, 0);

        // Sweep, with requests and issues pending to prove they are ignored.
        reset = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h3333;
        issue_valid = 1'b1; issue_rd = 5'd9; rs1_address = 5'd9;
        for (int i = 1; i <= 31; i++) begin
            tick();
            chk("sweep_we", reg_write, 1);
            chk("sweep_rd", rd_address, i);
            chk("sweep_data", write_data, 0);
            chk("sweep_init_done", init_done, 0);
            chk("sweep_alu_ready", alu_ready, 0);
        end
        alu_valid = 1'b0; issue_valid = 1'b0;
        tick();
        chk("sweep_end_we", reg_write, 0);
        chk("init_done_rise", init_done, 1);
        chk("sweep_issue_ignored", rs1_busy, 0);

        // Lone ALU request.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1111;
        #1;
        chk("alu_only_ready", alu_ready, 1);
        chk("alu_only_mem_ready", mem_ready, 0);
        tick();
        alu_valid = 1'b0;
        chk("alu_only_we", reg_write, 1);
        chk("alu_only_rd", rd_address, 5);
        chk("alu_only_data", write_data, 64'h1111);
        tick();
        chk("idle_we", reg_write, 0);

        // Contending pairs, held until accepted.
        for (int p = 0; p < 4; p++) begin
            alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 64'hAAAA;
            mem_valid = 1'b1; mem_rd = 5'd11; mem_data = 64'hBBBB;
            exp_q.push_back(5'd11);
            exp_q.push_back(5'd10);
            serve(8);
            chk("pair_cycles", serve_cycles, 2);
        end
        chk("pair_count", seen_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++)
            chk("pair_order", seen_q[i], exp_q[i]);

        // Scoreboard lifetime of x7.
        rs1_address = 5'd7; issue_valid = 1'b1; issue_rd = 5'd7;
        #1;
        chk("sb_before_issue", rs1_busy, 0);
        tick();
        issue_valid = 1'b0;
        chk("sb_after_issue", rs1_busy, 1);
        tick();
        chk("sb_hold", rs1_busy, 1);
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 64'h7777;
        #1;
        chk("sb_until_accept", rs1_busy, 1);
        tick();
        mem_valid = 1'b0;
        chk("sb_cleared", rs1_busy, 0);
        chk("sb_mem_we", reg_write, 1);
        chk("sb_mem_rd", rd_address, 7);
        chk("sb_mem_data", write_data, 64'h7777);
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        chk("sb_reissue", rs1_busy, 1);
        issue_valid = 1'b1; mem_valid = 1'b1;
        #1;
        chk("sb_same_ready", mem_ready, 1);
        tick();
        issue_valid = 1'b0; mem_valid = 1'b0;
        chk("sb_set_wins", rs1_busy, 1);
        mem_valid = 1'b1;
        tick();
        mem_valid = 1'b0;
        chk("sb_final_clear", rs1_busy, 0);

        // Transfer to x0.
        rs2_address = 5'd0; issue_valid = 1'b1; issue_rd = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hDEADBEEF;
        #1;
        chk("rd0_ready", alu_ready, 1);
        chk("rd0_busy_pre", rs2_busy, 0);
        tick();
        alu_valid = 1'b0; issue_valid = 1'b0;
        chk("rd0_no_write", reg_write, 0);
        chk("rd0_busy", rs2_busy, 0);

        // Reset while an ALU write to x31 is being accepted.
        issue_valid = 1'b1; issue_rd = 5'd31; rs1_address = 5'd31;
        tick();
        issue_valid = 1'b0;
        chk("rst_mid_busy_pre", rs1_busy, 1);
        alu_valid = 1'b1; alu_rd = 5'd31; alu_data = 64'h3131;
        reset = 1'b1;
        tick();
        reset = 1'b0; alu_valid = 1'b0;
        chk("rst_mid_we", reg_write, 0);
        chk("rst_mid_busy", rs1_busy, 0);
        chk("rst_mid_init_done", init_done, 0);
        tick();
        chk("rst_restart_we", reg_write, 1);
        chk("rst_restart_rd", rd_address, 1);
        repeat (31) tick();
        chk("rst_redone", init_done, 1);
        chk("rst_redone_we", reg_write, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
